count_bcd_disp: RTL and testbench
=================================

# count_bcd_disp

Downstream display stage for the 0–99 enable-gated counter. Accepts the counter's 8-bit binary value on a start pulse and converts it to three BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock. Holds the result in registers and drives three active-high seven-segment patterns with optional leading-zero blanking. Inputs 0–255 are fully supported, so the block also serves wider counters.

## Interface
- BLANK_LZ, 1, when 1 blank leading zero digits (hundreds, then tens); ones digit never blanked
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request conversion of `bin`; sampled only in IDLE
- bin  input  8  unsigned binary value to convert
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: new digits valid this cycle
- hund, tens, ones  output  4 each  registered BCD result
- seg_hund, seg_tens, seg_ones  output  7 each  segment patterns, bit order {g,f,e,d,c,b,a}, 1 = segment lit

## Operation
- FSM states: IDLE, SHIFT. One clock, asynchronous active-low reset.
- IDLE: if start=1, latch bin into shift register `sr`, clear 12-bit scratch `scr`, clear 3-bit iteration counter, go to SHIFT. Otherwise hold.
- SHIFT, each cycle: for each scratch nibble ≥5 add 3 (all three nibbles corrected in parallel from the same pre-shift value), then shift {scr, sr} left by one. Counter increments.
- On the 8th SHIFT cycle (counter = 7): load hund/tens/ones from the corrected-and-shifted scratch, pulse done, return to IDLE.
- start while busy: ignored; `bin` changes during SHIFT have no effect (value was latched).
- Result registers hold their value until the next completed conversion.
- Segment encoding (combinational from result registers, via decoder): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); codes 10–15 → 00.
- Blanking (BLANK_LZ=1): seg_hund=00 when hund=0; seg_tens=00 when hund=0 and tens=0. BLANK_LZ=0: no blanking.

## Timing
- Reset (rst_n=0, any time, including mid-SHIFT): state IDLE, busy=0, done=0, hund=tens=ones=0, sr/scr/counter cleared. Segments then: seg_ones=3F; seg_tens=seg_hund=00 (BLANK_LZ=1) or 3F (BLANK_LZ=0).
- start sampled at edge E0 → busy=1 from E0. Shift steps at E1..E8. At E8: digits update, done=1, busy=0. done falls at E9.
- Start-to-done latency: 8 cycles. Minimum start spacing: 9 cycles (start accepted earliest at E9, i.e. while done is high).
- busy and done are never high in the same cycle.
- Segment outputs change in the same cycle as the digit registers (combinational, no extra latency).

## Structure
- Shared package count_pkg: FSM state enum (IDLE, SHIFT), the ten segment constants, SEG_BLANK = 7'h00, ITER_LAST = 3'd7.
- Sub-module ssdec: 4-bit BCD in → 7-bit pattern out, pure combinational, instantiated three times.
- Blanking logic and FSM stay in the top module.

## Test plan
- Reset: hold rst_n=0 → busy=0, done=0, digits 0/0/0, seg_ones=3F, seg_tens=seg_hund=00.
- bin=99, start 1 cycle → busy 8 cycles, done at 8th edge, hund=0 tens=9 ones=9, seg_tens=seg_ones=6F, seg_hund=00.
- bin=255 → hund=2 tens=5 ones=5, segs 5B/6D/6D; then bin=7 → 0/0/7, seg_ones=07, tens and hund blanked.
- Counter wrap: convert 99 then 0 → ones=0, seg_ones=3F, tens/hund blanked; with BLANK_LZ=0 all three 3F.
- start pulsed at cycles 3 and 5 of a conversion, bin changed mid-run → ignored; result matches value latched at E0, single done.
- rst_n asserted during SHIFT cycle 4 → immediate IDLE, outputs zero, no done; next start converts correctly.

Source files
------------

// File: rtl/count_bcd_disp_pkg.sv
// -----------------------------------------------------------------------------
// count_pkg
//   Shared definitions for the count_bcd_disp display stage: FSM state type,
//   seven-segment constants (bit order {g,f,e,d,c,b,a}, 1 = lit), the last
//   iteration index of the double-dabble engine, and the per-nibble
//   add-3 correction helper.
// -----------------------------------------------------------------------------
package count_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Eight input bits -> iterations 0..7.
  localparam logic [2:0] ITER_LAST = 3'd7;

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after the
  // next doubling, so pre-add 3 to carry cleanly into the next decade.
  function automatic logic [3:0] dd_fix(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/count_bcd_disp_if.sv
// -----------------------------------------------------------------------------
// count_bcd_disp_if
//   Bundle of the conversion request and display result signals.
//   master : request side (drives start/bin, observes everything else)
//   slave  : count_bcd_disp itself
//   Signals:
//     start               conversion request, sampled only when idle
//     bin[7:0]            unsigned value to convert
//     busy                conversion in progress
//     done                one-cycle pulse, new digits valid
//     hund/tens/ones[3:0] registered BCD digits
//     seg_*[6:0]          seven-segment patterns {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
interface count_bcd_disp_if;
  logic       start;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] seg_hund;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;

  modport master (
    output start, bin,
    input  busy, done, hund, tens, ones, seg_hund, seg_tens, seg_ones
  );

  modport slave (
    input  start, bin,
    output busy, done, hund, tens, ones, seg_hund, seg_tens, seg_ones
  );
endinterface

// File: rtl/count_bcd_disp_ssdec.sv
// -----------------------------------------------------------------------------
// ssdec
//   Combinational BCD to seven-segment decoder, active-high segments,
//   bit order {g,f,e,d,c,b,a}. Non-decimal codes 10..15 light nothing.
//   Ports:
//     bcd[3:0]  digit in
//     seg[6:0]  segment pattern out
// -----------------------------------------------------------------------------
module ssdec
  import count_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for codes the case does not list.
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_bcd_disp.sv
// -----------------------------------------------------------------------------
// count_bcd_disp
//   Display stage: converts an 8-bit binary value to three BCD digits with an
//   iterative shift-add-3 (double-dabble) engine, one bit per clock, holds the
//   digits in registers and drives three seven-segment patterns with optional
//   leading-zero blanking.
//   Parameters:
//     BLANK_LZ  1: blank leading zero hundreds/tens digits; ones never blanked
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    count_bcd_disp_if.slave (start/bin in; busy/done/digits/segs out)
//   Timing: start accepted at E0, shifts at E1..E8, digits + done at E8.
// -----------------------------------------------------------------------------
module count_bcd_disp
  import count_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  count_bcd_disp_if.slave bus
);

  state_t      state;
  logic [7:0]  sr;
  logic [11:0] scr;
  logic [2:0]  cnt;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  hund_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;

  logic [11:0] scr_fix;
  logic [11:0] scr_next;

  // All three nibbles are corrected from the same pre-shift value, then the
  // whole {scr, sr} pair moves left by one.
  always_comb begin
    scr_fix  = {dd_fix(scr[11:8]), dd_fix(scr[7:4]), dd_fix(scr[3:0])};
    scr_next = {scr_fix[10:0], sr[7]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sr     <= '0;
      scr    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hund_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr     <= bus.bin;
            scr    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          scr <= scr_next;
          sr  <= {sr[6:0], 1'b0};
          cnt <= cnt + 3'd1;
          if (cnt == ITER_LAST) begin
            hund_q <= scr_next[11:8];
            tens_q <= scr_next[7:4];
            ones_q <= scr_next[3:0];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [6:0] dec_hund;
  logic [6:0] dec_tens;
  logic [6:0] dec_ones;

  ssdec u_dec_hund (.bcd(hund_q), .seg(dec_hund));
  ssdec u_dec_tens (.bcd(tens_q), .seg(dec_tens));
  ssdec u_dec_ones (.bcd(ones_q), .seg(dec_ones));

  logic blank_hund;
  logic blank_tens;

  // Tens is only a leading zero when hundreds is one too.
  always_comb begin
    blank_hund = BLANK_LZ && (hund_q == 4'd0);
    blank_tens = blank_hund && (tens_q == 4'd0);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hund     = hund_q;
  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;
  assign bus.seg_hund = blank_hund ? SEG_BLANK : dec_hund;
  assign bus.seg_tens = blank_tens ? SEG_BLANK : dec_tens;
  assign bus.seg_ones = dec_ones;

endmodule

// File: tb/tb_count_bcd_disp.sv
// -----------------------------------------------------------------------------
// tb_count_bcd_disp
//   Drives two instances of count_bcd_disp (BLANK_LZ=1 and BLANK_LZ=0) with
//   identical stimulus and compares them against a decimal reference model
//   (divide/modulo digits plus a segment lookup table).
// -----------------------------------------------------------------------------
module tb_count_bcd_disp;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  count_bcd_disp_if if1 ();
  count_bcd_disp_if if0 ();

  count_bcd_disp #(.BLANK_LZ(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  count_bcd_disp #(.BLANK_LZ(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] b);
    if1.start = s; if1.bin = b;
    if0.start = s; if0.bin = b;
  endtask

  // Compare digits and segments of both instances against the model for v.
  task automatic check_value(input string tag, input int v);
    int h, t, o;
    logic [6:0] e_h1, e_t1;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    e_h1 = (h == 0) ? 7'h00 : seg_tab[h];
    e_t1 = (h == 0 && t == 0) ? 7'h00 : seg_tab[t];
    check({tag, ".hund"},      32'(if1.hund), 32'(h));
    check({tag, ".tens"},      32'(if1.tens), 32'(t));
    check({tag, ".ones"},      32'(if1.ones), 32'(o));
    check({tag, ".seg_hund1"}, 32'(if1.seg_hund), 32'(e_h1));
    check({tag, ".seg_tens1"}, 32'(if1.seg_tens), 32'(e_t1));
    check({tag, ".seg_ones1"}, 32'(if1.seg_ones), 32'(seg_tab[o]));
    check({tag, ".seg_hund0"}, 32'(if0.seg_hund), 32'(seg_tab[h]));
    check({tag, ".seg_tens0"}, 32'(if0.seg_tens), 32'(seg_tab[t]));
    check({tag, ".seg_ones0"}, 32'(if0.seg_ones), 32'(seg_tab[o]));
  endtask

  // One full conversion with cycle-by-cycle busy/done checks. With inject set,
  // start is re-pulsed before E3 and E5 and bin is scrambled mid-run.
  task automatic convert(input string tag, input logic [7:0] v, input bit inject);
    @(negedge clk);
    drive(1'b1, v);
    @(negedge clk);                       // after E0
    check({tag, ".busy_e0"}, 32'(if1.busy), 32'd1);
    check({tag, ".done_e0"}, 32'(if1.done), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      if (inject && (k == 3 || k == 5)) drive(1'b1, 8'($urandom));
      else if (inject)                  drive(1'b0, 8'($urandom));
      else                              drive(1'b0, v);
      @(negedge clk);                     // after Ek
      if (k < 8) begin
        check($sformatf("%s.busy_e%0d", tag, k), 32'(if1.busy), 32'd1);
        check($sformatf("%s.done_e%0d", tag, k), 32'(if1.done), 32'd0);
      end else begin
        check({tag, ".busy_e8"},  32'(if1.busy), 32'd0);
        check({tag, ".done_e8"},  32'(if1.done), 32'd1);
        check({tag, ".done0_e8"}, 32'(if0.done), 32'd1);
        check_value(tag, int'(v));
      end
    end
    drive(1'b0, v);
    @(negedge clk);                       // after E9
    check({tag, ".done_e9"}, 32'(if1.done), 32'd0);
    check({tag, ".busy_e9"}, 32'(if1.busy), 32'd0);
    check_value({tag, ".hold"}, int'(v));
  endtask

  initial begin
    int dones;
    drive(1'b0, 8'd0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(if1.busy), 32'd0);
    check("rst.done", 32'(if1.done), 32'd0);
    check_value("rst", 0);
    rst_n = 1'b1;
    @(negedge clk);

    convert("v99",  8'd99,  1'b0);
    convert("v255", 8'd255, 1'b0);
    convert("v7",   8'd7,   1'b0);
    convert("w99",  8'd99,  1'b0);
    convert("w0",   8'd0,   1'b0);
    convert("v100", 8'd100, 1'b0);
    convert("inj",  8'd173, 1'b1);

    // Reset during the fourth shift cycle: abort, no done afterwards.
    @(negedge clk);
    drive(1'b1, 8'd88);
    @(negedge clk);
    drive(1'b0, 8'd88);
    repeat (4) @(negedge clk);            // after E4
    check("mid.busy_pre", 32'(if1.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.busy", 32'(if1.busy), 32'd0);
    check("mid.done", 32'(if1.done), 32'd0);
    check_value("mid", 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if1.done) dones++;
    end
    check("mid.no_done", 32'(dones), 32'd0);
    convert("after_rst", 8'd42, 1'b0);

    // Randomized values; busy and done must never coincide.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      convert($sformatf("rnd%0d", i), r, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!(if1.busy && if1.done)) else begin
        bad++;
        $error("FAIL busy_done_overlap observed=%0b%0b expected=not both", if1.busy, if1.done);
      end
    end
  end

endmodule
